// File: rtl/stw_bist_sequencer.sv
// Self-test sequencer for the systolic STW path: walks NUM_PATTERNS operand sets through every PE,
// waits for aggregate completion, and accumulates per-PE mismatches into a sticky fault map.
module stw_bist_sequencer #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int WORD_SIZE    = 16,
    parameter int NUM_PATTERNS = 4,
    parameter int PAT_SEED     = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bist_start,
    output logic                      bist_busy,
    output logic                      bist_done,
    output logic                      array_hold,
    output logic [WORD_SIZE-1:0]      STW_mult_op1,
    output logic [WORD_SIZE-1:0]      STW_mult_op2,
    output logic [WORD_SIZE-1:0]      STW_add_op,
    output logic [WORD_SIZE-1:0]      STW_expected,
    output logic                      STW_test_load_en,
    output logic                      STW_start,
    input  logic                      STW_complete_in,
    input  logic [ROWS*COLS-1:0]      STW_result_in,
    output logic [ROWS*COLS-1:0]      fault_map,
    output logic                      fault_any,
    output logic                      timeout_err,
    output logic [$clog2(NUM_PATTERNS > 1 ? NUM_PATTERNS : 2)-1:0] pattern_idx
);

    localparam int PW = $clog2(NUM_PATTERNS > 1 ? NUM_PATTERNS : 2);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] LAST_PAT  = PW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        wait_cnt;
    logic [PW-1:0]        pat_sel;
    logic [WORD_SIZE-1:0] pat_w;
    logic [WORD_SIZE-1:0] nxt_op1;
    logic [WORD_SIZE-1:0] nxt_op2;
    logic [WORD_SIZE-1:0] nxt_add;
    logic [WORD_SIZE-1:0] nxt_exp;

    // Operands for the pattern about to be loaded: 0 from IDLE, idx+1 from CAPTURE.
    always_comb begin
        pat_sel = (state == S_CAPTURE) ? pattern_idx + PW'(1) : '0;
        pat_w   = WORD_SIZE'(pat_sel);
        nxt_op1 = WORD_SIZE'(PAT_SEED) + pat_w;
        nxt_op2 = pat_w + WORD_SIZE'(2);
        nxt_add = pat_w;
        nxt_exp = nxt_op1 * nxt_op2 + nxt_add;
    end

    always_comb begin
        state_nxt        = state;
        bist_busy        = 1'b1;
        bist_done        = 1'b0;
        STW_test_load_en = 1'b0;
        STW_start        = 1'b0;
        case (state)
            S_IDLE: begin
                bist_busy = 1'b0;
                if (bist_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                STW_test_load_en = 1'b1;
                state_nxt        = S_START;
            end
            S_START: begin
                STW_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (STW_complete_in)            state_nxt = S_CAPTURE;
                else if (wait_cnt == WAIT_LAST) state_nxt = S_DONE;
            end
            S_CAPTURE: begin
                state_nxt = (pattern_idx == LAST_PAT) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                bist_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign array_hold = bist_busy;
    assign fault_any  = |fault_map;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pattern_idx  <= '0;
            wait_cnt     <= '0;
            fault_map    <= '0;
            timeout_err  <= 1'b0;
            STW_mult_op1 <= '0;
            STW_mult_op2 <= '0;
            STW_add_op   <= '0;
            STW_expected <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bist_start) begin
                        pattern_idx <= '0;
                        wait_cnt    <= '0;
                        fault_map   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_START: wait_cnt <= '0;
                S_WAIT: begin
                    if (!STW_complete_in) begin
                        // Timeout poisons the whole map: no PE result can be trusted.
                        if (wait_cnt == WAIT_LAST) begin
                            timeout_err <= 1'b1;
                            fault_map   <= '1;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    fault_map <= fault_map | STW_result_in;
                    if (pattern_idx != LAST_PAT) pattern_idx <= pattern_idx + PW'(1);
                end
                default: ;
            endcase

            if (state_nxt == S_LOAD) begin
                STW_mult_op1 <= nxt_op1;
                STW_mult_op2 <= nxt_op2;
                STW_add_op   <= nxt_add;
                STW_expected <= nxt_exp;
            end else if (state == S_DONE) begin
                STW_mult_op1 <= '0;
                STW_mult_op2 <= '0;
                STW_add_op   <= '0;
                STW_expected <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stw_bist_sequencer.sv
// Directed bench for stw_bist_sequencer: default 4-pattern instance plus a 1-pattern wrap instance.
`timescale 1ns/1ps
module tb_stw_bist_sequencer;

    localparam int W = 16;
    localparam int M = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         bist_start = 1'b0;
    logic         cmpl = 1'b0;
    logic [M-1:0] res = '0;
    logic         busy, done, hold, load_en, stw_start, fault_any, tmo;
    logic [W-1:0] op1, op2, addo, expo;
    logic [M-1:0] fmap;
    logic [1:0]   pidx;

    logic         bist_start_b = 1'b0;
    logic         cmpl_b = 1'b0;
    logic [M-1:0] res_b = '0;
    logic         busy_b, done_b, hold_b, load_en_b, stw_start_b, fault_any_b, tmo_b;
    logic [W-1:0] op1_b, op2_b, addo_b, expo_b;
    logic [M-1:0] fmap_b;
    logic [0:0]   pidx_b;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           pat_seen = 0;
    int           fail_pat = -1;
    logic         pe_ok = 1'b1;
    logic [M-1:0] fail_mask = '0;

    stw_bist_sequencer dut (
        .clk(clk), .rst(rst), .bist_start(bist_start),
        .bist_busy(busy), .bist_done(done), .array_hold(hold),
        .STW_mult_op1(op1), .STW_mult_op2(op2), .STW_add_op(addo), .STW_expected(expo),
        .STW_test_load_en(load_en), .STW_start(stw_start),
        .STW_complete_in(cmpl), .STW_result_in(res),
        .fault_map(fmap), .fault_any(fault_any), .timeout_err(tmo), .pattern_idx(pidx)
    );

    stw_bist_sequencer #(.NUM_PATTERNS(1), .PAT_SEED(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .bist_start(bist_start_b),
        .bist_busy(busy_b), .bist_done(done_b), .array_hold(hold_b),
        .STW_mult_op1(op1_b), .STW_mult_op2(op2_b), .STW_add_op(addo_b), .STW_expected(expo_b),
        .STW_test_load_en(load_en_b), .STW_start(stw_start_b),
        .STW_complete_in(cmpl_b), .STW_result_in(res_b),
        .fault_map(fmap_b), .fault_any(fault_any_b), .timeout_err(tmo_b), .pattern_idx(pidx_b)
    );

    // PE array model: complete rises the cycle after STW_start, clears on load.
    task automatic pe_tick();
        if (!pe_ok) begin
            cmpl = 1'b0;
        end else if (stw_start) begin
            cmpl = 1'b1;
            res  = (pat_seen == fail_pat) ? fail_mask : '0;
            pat_seen++;
        end else if (load_en) begin
            cmpl = 1'b0;
            res  = '0;
        end
        if (stw_start_b) cmpl_b = 1'b1;
        else if (load_en_b) cmpl_b = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        pe_tick();
        cyc++;
    endtask

    task automatic launch();
        pat_seen   = 0;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, done, hold, load_en, stw_start} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl got %b want 00000", {busy, done, hold, load_en, stw_start});
        end
        tests++;
        if ({op1, op2, addo, expo} !== 64'h0) begin
            fails++;
            $display("FAIL reset_ops got %h want 0", {op1, op2, addo, expo});
        end
        tests++;
        if ({fmap, fault_any, tmo, pidx} !== 20'h0) begin
            fails++;
            $display("FAIL reset_status got %h want 0", {fmap, fault_any, tmo, pidx});
        end
        tests++;
        if ({busy_b, done_b, load_en_b, stw_start_b, op1_b, expo_b, fmap_b} !== 52'h0) begin
            fails++;
            $display("FAIL reset_b got %h want 0", {busy_b, done_b, load_en_b, stw_start_b, op1_b, expo_b, fmap_b});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_healthy();
        logic [4*W-1:0] tbl [4];
        logic [4:0]     ctl;
        logic [4*W-1:0] eop;
        int             p;
        tbl[0] = {16'd3, 16'd2, 16'd0, 16'd6};
        tbl[1] = {16'd4, 16'd3, 16'd1, 16'd13};
        tbl[2] = {16'd5, 16'd4, 16'd2, 16'd22};
        tbl[3] = {16'd6, 16'd5, 16'd3, 16'd33};
        pe_ok = 1'b1;
        fail_pat = -1;
        launch();
        for (int k = 1; k <= 18; k++) begin
            ctl[4] = (k <= 17);
            ctl[3] = (k == 17);
            ctl[2] = (k <= 17);
            ctl[1] = (k <= 16) && (k % 4 == 1);
            ctl[0] = (k <= 16) && (k % 4 == 2);
            p = (k - 1) / 4;
            if (p > 3) p = 3;
            eop = (k <= 17) ? tbl[p] : '0;
            tests++;
            if ({busy, done, hold, load_en, stw_start} !== ctl) begin
                fails++;
                $display("FAIL healthy_ctl cyc %0d got %b want %b", k, {busy, done, hold, load_en, stw_start}, ctl);
            end
            tests++;
            if ({op1, op2, addo, expo} !== eop) begin
                fails++;
                $display("FAIL healthy_ops cyc %0d got %h want %h", k, {op1, op2, addo, expo}, eop);
            end
            if (k < 18) tick();
        end
        tests++;
        if ({fmap, fault_any, tmo, pidx} !== {16'h0, 1'b0, 1'b0, 2'd3}) begin
            fails++;
            $display("FAIL healthy_status got %h want %h", {fmap, fault_any, tmo, pidx}, {16'h0, 1'b0, 1'b0, 2'd3});
        end
    endtask

    task automatic test_fault_map();
        int n;
        pe_ok = 1'b1;
        fail_pat = 2;
        fail_mask = 16'h0020;
        launch();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (cyc !== 17) begin
            fails++;
            $display("FAIL fault_done_cycle got %0d want 17", cyc);
        end
        tick();
        tests++;
        if ({fmap, fault_any, tmo} !== {16'h0020, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL fault_map got %h want %h", {fmap, fault_any, tmo}, {16'h0020, 1'b1, 1'b0});
        end
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if ({busy, fmap, fault_any} !== {1'b0, 16'h0020, 1'b1}) begin
            fails++;
            $display("FAIL fault_persist got %h want %h", {busy, fmap, fault_any}, {1'b0, 16'h0020, 1'b1});
        end
        fail_pat = -1;
    endtask

    task automatic test_timeout();
        int n;
        pe_ok = 1'b0;
        launch();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (cyc !== 67) begin
            fails++;
            $display("FAIL timeout_done_cycle got %0d want 67", cyc);
        end
        tests++;
        if ({tmo, fmap, fault_any} !== {1'b1, 16'hFFFF, 1'b1}) begin
            fails++;
            $display("FAIL timeout_status got %h want %h", {tmo, fmap, fault_any}, {1'b1, 16'hFFFF, 1'b1});
        end
        tick();
        pe_ok = 1'b1;
    endtask

    task automatic test_back_to_back();
        int dones;
        int n;
        pe_ok = 1'b1;
        fail_pat = 1;
        fail_mask = 16'h0001;
        launch();
        tick();
        tick();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        dones = 0;
        while (cyc < 17) begin
            if (done === 1'b1) dones++;
            tick();
        end
        if (done === 1'b1) dones++;
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL ignore_done_pulses got %0d want 1", dones);
        end
        bist_start = 1'b1;
        tick();
        tests++;
        if ({busy, done, fmap} !== {1'b0, 1'b0, 16'h0001}) begin
            fails++;
            $display("FAIL done_hold_idle got %h want %h", {busy, done, fmap}, {1'b0, 1'b0, 16'h0001});
        end
        pat_seen = 0;
        fail_pat = -1;
        tick();
        bist_start = 1'b0;
        tests++;
        if ({busy, load_en, fmap, pidx} !== {1'b1, 1'b1, 16'h0, 2'd0}) begin
            fails++;
            $display("FAIL restart_clear got %h want %h", {busy, load_en, fmap, pidx}, {1'b1, 1'b1, 16'h0, 2'd0});
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if ({cyc, fmap} !== {32'd35, 16'h0}) begin
            fails++;
            $display("FAIL restart_done got cyc %0d map %h want cyc 35 map 0000", cyc, fmap);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        pe_ok = 1'b1;
        fail_pat = -1;
        launch();
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if ({busy, load_en, stw_start, pidx} !== {1'b1, 1'b0, 1'b0, 2'd1}) begin
            fails++;
            $display("FAIL midrst_wait got %b want %b", {busy, load_en, stw_start, pidx}, {1'b1, 1'b0, 1'b0, 2'd1});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, done, hold, load_en, stw_start, op1, op2, addo, expo, fmap, tmo, pidx} !== 88'h0) begin
            fails++;
            $display("FAIL midrst_clear got %h want 0",
                     {busy, done, hold, load_en, stw_start, op1, op2, addo, expo, fmap, tmo, pidx});
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | busy | load_en | stw_start | done;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midrst_quiet got %b want 0", seen);
        end
    endtask

    task automatic test_wrap();
        int n;
        bist_start_b = 1'b1;
        tick();
        bist_start_b = 1'b0;
        cyc = 1;
        tests++;
        if ({load_en_b, op1_b, op2_b, addo_b, expo_b} !== {1'b1, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFE}) begin
            fails++;
            $display("FAIL wrap_ops got %h want %h", {load_en_b, op1_b, op2_b, addo_b, expo_b},
                     {1'b1, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFE});
        end
        n = 0;
        while (done_b !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (cyc !== 5) begin
            fails++;
            $display("FAIL wrap_done_cycle got %0d want 5", cyc);
        end
        tests++;
        if ({fmap_b, tmo_b, pidx_b} !== 18'h0) begin
            fails++;
            $display("FAIL wrap_status got %h want 0", {fmap_b, tmo_b, pidx_b});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_healthy();
        test_fault_map();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
